forloop_pattern_gen: RTL and testbench
======================================

# forloop_pattern_gen

Parametrised multi-channel test-pattern generator built from per-channel, per-bit generate loops. Each channel drives a WIDTH-bit register that is either a static stripe pattern or advances on an enable as a walking one, a binary counter or a PRBS sequence. The block feeds datapath and TMR regression benches and on-chip self-test paths. All channels share one mode and one control FSM.

## Interface
- WIDTH, 32, bits per channel (≥ 2)
- CHANNELS, 4, number of channels; must satisfy CHANNELS ≤ WIDTH and CHANNELS < 2^WIDTH − 1
- PHASE_MOD, 2, stripe period for STATIC mode (≥ 2)
- POLY, 32'h0040_0007, Galois LFSR feedback mask (low WIDTH bits used; default gives x^32+x^22+x^2+x+1)

- c  in  1  clock, all logic on rising edge
- r  in  1  reset, synchronous, active-high
- mode  in  2  0 STATIC, 1 WALK, 2 COUNT, 3 PRBS
- mode_ld  in  1  load mode and seed all channels
- en  in  1  advance all channels one step
- a  out  CHANNELS*WIDTH  channel k occupies a[k*WIDTH +: WIDTH]
- valid  out  1  a holds a seeded pattern
- wrap  out  1  one-cycle pulse, channel 0 completed a period

## Operation
- FSM: IDLE, RUN. Reset → IDLE. IDLE + mode_ld → RUN. RUN + mode_ld → RUN (reseed). No other exits; only r returns to IDLE.
- Reset values: a = 0, valid = 0, wrap = 0, mode register = STATIC, state IDLE.
- mode_ld: latch mode, load seeds, valid ← 1.
- Seeds, channel k, bit j:
  - STATIC: bit j = 1 iff (j % PHASE_MOD) == PHASE_MOD − 1 (PHASE_MOD=2 → j%2 stripe). Identical for all channels.
  - WALK: one-hot, bit k set.
  - COUNT: value k.
  - PRBS: bitwise NOT of k zero-extended (never zero).
- en in RUN, per channel:
  - STATIC: no change.
  - WALK: rotate left by 1 (bit WIDTH−1 → bit 0).
  - COUNT: +1 modulo 2^WIDTH.
  - PRBS: next = {x[WIDTH−2:0],0} XOR (x[WIDTH−1] ? POLY : 0).
- wrap (channel 0 only, on an en step): WALK when bit WIDTH−1 rotates into bit 0; COUNT when all-ones → 0; PRBS when next value equals the channel-0 seed; STATIC never.
- Priority: r > mode_ld > en. mode_ld with en same cycle: reseed only, en dropped, wrap = 0.
- en in IDLE: ignored, a stays 0, valid stays 0.
- mode input sampled only on mode_ld; changes otherwise have no effect.

## Timing
- mode_ld at edge n → a = seeds, valid = 1 visible after edge n.
- en at edge n → advanced a after edge n; wrap asserted after same edge, cleared next edge unless wrap recurs.
- Back-to-back en every cycle: one step per cycle, no bubbles.
- r at any cycle, including mid-sequence: all outputs to reset values after that edge; following mode_ld behaves as from power-up.
- Latency from any input to outputs: exactly 1 cycle; all outputs registered.

## Configuration
- FORLOOP_PATTERN_GEN_PRBS_EN defined: PRBS mode and LFSR logic compiled in as above.
- Not defined: no LFSR logic; mode 3 on mode_ld is latched as STATIC (seeds and behaviour identical to mode 0); POLY unused.

## Test plan
- Reset then mode_ld, mode=0, WIDTH=32 → every channel = 32'hAAAA_AAAA, valid=1; 10 en pulses → unchanged, wrap never asserted.
- mode=1, 32 en pulses → channel 0 steps 1,2,4,…,32'h8000_0000 then 1 with wrap high only on the 32nd step; channel 3 starts at 8.
- mode=2, WIDTH=8 → channel 0 counts 0…255; wrap on 255→0; channel 2 starts at 2; en in IDLE before load leaves a=0, valid=0.
- mode=3 with macro, WIDTH=32 → channel 0 seed 32'hFFFF_FFFF, first step 32'hFFFF_FFFE XOR 32'h0040_0007 = 32'hFFBF_FFF9; without macro same stimulus → 32'hAAAA_AAAA static.
- mode_ld and en same cycle mid-COUNT (ch0=17, mode=1) → ch0 = 1, no step applied, wrap=0.
- r asserted mid-WALK with en high → next cycle a=0, valid=0, wrap=0, state IDLE; subsequent en ignored until mode_ld.

Source files
------------

// File: rtl/forloop_pattern_gen.sv
// ============================================================================
// Module   : forloop_pattern_gen
// Purpose  : Multi-channel test-pattern generator. Each channel holds a
//            WIDTH-bit register that is seeded on mode_ld and then either
//            stays put (STATIC stripe) or advances on en as a walking one,
//            a binary counter or a Galois LFSR (PRBS).
// Options  : FORLOOP_PATTERN_GEN_PRBS_EN - compiles in the PRBS mode and the
//            LFSR logic. Without it, mode 3 is latched as STATIC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module forloop_pattern_gen #(
    parameter int               WIDTH     = 32,
    parameter int               CHANNELS  = 4,
    parameter int               PHASE_MOD = 2,
    parameter logic [WIDTH-1:0] POLY      = WIDTH'(32'h0040_0007)
) (
    input  logic                      c,
    input  logic                      r,
    input  logic [1:0]                mode,
    input  logic                      mode_ld,
    input  logic                      en,
    output logic [CHANNELS*WIDTH-1:0] a,
    output logic                      valid,
    output logic                      wrap
);

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_WALK   = 2'd1;
    localparam logic [1:0] MODE_COUNT  = 2'd2;
    localparam logic [1:0] MODE_PRBS   = 2'd3;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] a_q [CHANNELS];
    logic [WIDTH-1:0] a_d [CHANNELS];

    // Per-channel seed (for the incoming mode) and next-step value (for the
    // latched mode), built by the generate loops below.
    logic [WIDTH-1:0] w_seed [CHANNELS];
    logic [WIDTH-1:0] w_step [CHANNELS];

    // Channel-0 candidates used to detect the end of a period.
    logic [WIDTH-1:0] w_prbs_step0;
    logic [WIDTH-1:0] w_prbs_seed0;
    logic             w_wrap0;
    logic [1:0]       w_mode_eff;

    // Mode value that mode_ld will latch; PRBS folds to STATIC when the
    // LFSR is not built so that mode_q never selects missing logic.
`ifdef FORLOOP_PATTERN_GEN_PRBS_EN
    always_comb begin
        w_mode_eff = mode;
    end
`else
    always_comb begin
        w_mode_eff = (mode == MODE_PRBS) ? MODE_STATIC : mode;
    end

    logic w_poly_unused;
    assign w_poly_unused = ^POLY;
`endif

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0] w_seed_static;
        logic [WIDTH-1:0] w_seed_walk;
        logic [WIDTH-1:0] w_seed_count;
        logic [WIDTH-1:0] w_step_walk;
        logic [WIDTH-1:0] w_step_count;
        logic [WIDTH-1:0] w_seed_prbs;
        logic [WIDTH-1:0] w_step_prbs;

        for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            // Stripe: the last bit of every PHASE_MOD-long group is set.
            assign w_seed_static[j] = ((j % PHASE_MOD) == (PHASE_MOD - 1));
            // Walking one starts at the bit matching the channel index.
            assign w_seed_walk[j]   = (j == k);
            // Rotate left: bit j takes its lower neighbour, bit 0 the MSB.
            assign w_step_walk[j]   = a_q[k][(j + WIDTH - 1) % WIDTH];
        end

        assign w_seed_count = WIDTH'(k);
        assign w_step_count = a_q[k] + WIDTH'(1);

`ifdef FORLOOP_PATTERN_GEN_PRBS_EN
        // Non-zero seed so the LFSR never locks up.
        assign w_seed_prbs = ~WIDTH'(k);

        for (genvar j = 0; j < WIDTH; j++) begin : g_lfsr
            if (j == 0) begin : g_lsb
                assign w_step_prbs[j] = a_q[k][WIDTH-1] & POLY[j];
            end else begin : g_upper
                assign w_step_prbs[j] = a_q[k][j-1] ^ (a_q[k][WIDTH-1] & POLY[j]);
            end
        end
`else
        assign w_seed_prbs = w_seed_static;
        assign w_step_prbs = a_q[k];
`endif

        // Seed selected by the mode being loaded.
        always_comb begin
            case (w_mode_eff)
                MODE_WALK:  w_seed[k] = w_seed_walk;
                MODE_COUNT: w_seed[k] = w_seed_count;
                MODE_PRBS:  w_seed[k] = w_seed_prbs;
                default:    w_seed[k] = w_seed_static;
            endcase
        end

        // Next value for the currently latched mode; STATIC holds.
        always_comb begin
            case (mode_q)
                MODE_WALK:  w_step[k] = w_step_walk;
                MODE_COUNT: w_step[k] = w_step_count;
                MODE_PRBS:  w_step[k] = w_step_prbs;
                default:    w_step[k] = a_q[k];
            endcase
        end

        if (k == 0) begin : g_ch0_taps
            assign w_prbs_step0 = w_step_prbs;
            assign w_prbs_seed0 = w_seed_prbs;
        end

        assign a[k*WIDTH +: WIDTH] = a_q[k];
    end

    // Period-end detection for channel 0 on the step about to be taken.
    always_comb begin
        case (mode_q)
            MODE_WALK:  w_wrap0 = a_q[0][WIDTH-1];
            MODE_COUNT: w_wrap0 = &a_q[0];
`ifdef FORLOOP_PATTERN_GEN_PRBS_EN
            MODE_PRBS:  w_wrap0 = (w_prbs_step0 == w_prbs_seed0);
`endif
            default:    w_wrap0 = 1'b0;
        endcase
    end

    // Next-state: mode_ld reseeds (and swallows en), en advances only in RUN.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            a_d[k] = a_q[k];
        end

        if (mode_ld) begin
            state_d = S_RUN;
            mode_d  = w_mode_eff;
            valid_d = 1'b1;
            for (int k = 0; k < CHANNELS; k++) begin
                a_d[k] = w_seed[k];
            end
        end else if ((state_q == S_RUN) && en) begin
            wrap_d = w_wrap0;
            for (int k = 0; k < CHANNELS; k++) begin
                a_d[k] = w_step[k];
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge c) begin
        if (r) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_STATIC;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                a_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            for (int k = 0; k < CHANNELS; k++) begin
                a_q[k] <= a_d[k];
            end
        end
    end

    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_forloop_pattern_gen.sv
// ============================================================================
// Module   : tb_forloop_pattern_gen
// Purpose  : Directed and randomized checks of forloop_pattern_gen at
//            WIDTH=32 and WIDTH=8 against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_forloop_pattern_gen;

    localparam int CH = 4;

    logic         c = 1'b0;
    logic         r = 1'b1;
    logic [1:0]   mode = 2'd0;
    logic         mode_ld = 1'b0;
    logic         en = 1'b0;
    logic [127:0] a32;
    logic         valid32, wrap32;
    logic [31:0]  a8;
    logic         valid8, wrap8;

    always #5 c = ~c;

    forloop_pattern_gen #(.WIDTH(32), .CHANNELS(CH), .PHASE_MOD(2), .POLY(32'h0040_0007)) u_dut32 (
        .c(c), .r(r), .mode(mode), .mode_ld(mode_ld), .en(en),
        .a(a32), .valid(valid32), .wrap(wrap32)
    );

    forloop_pattern_gen #(.WIDTH(8), .CHANNELS(CH), .PHASE_MOD(2), .POLY(8'h07)) u_dut8 (
        .c(c), .r(r), .mode(mode), .mode_ld(mode_ld), .en(en),
        .a(a8), .valid(valid8), .wrap(wrap8)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: index d=0 is the 32-bit instance, d=1 the 8-bit.
    // ------------------------------------------------------------------
    int          m_w    [2] = '{32, 8};
    logic [63:0] m_poly [2] = '{64'h0040_0007, 64'h07};
    logic [63:0] m_val  [2][CH];
    bit          m_run  [2];
    bit          m_valid[2];
    bit          m_wrap [2];
    int          m_mode [2];

    function automatic logic [63:0] wmask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] seed(input int w, input int md, input int k);
        logic [63:0] s = 64'd0;
        case (md)
            1: s = 64'd1 << k;
            2: s = 64'(k);
            3: s = ~64'(k) & wmask(w);
            default: begin
                for (int j = 0; j < w; j++)
                    if ((j % 2) == 1) s = s | (64'd1 << j);
            end
        endcase
        return s;
    endfunction

    task automatic model_edge(input bit rr, input int md, input bit ld, input bit e);
        for (int d = 0; d < 2; d++) begin
            int          w = m_w[d];
            logic [63:0] m = wmask(w);
            m_wrap[d] = 1'b0;
            if (rr) begin
                m_run[d] = 0; m_valid[d] = 0; m_mode[d] = 0;
                for (int k = 0; k < CH; k++) m_val[d][k] = 64'd0;
            end else if (ld) begin
                int eff = md;
`ifndef FORLOOP_PATTERN_GEN_PRBS_EN
                if (eff == 3) eff = 0;
`endif
                m_run[d] = 1; m_valid[d] = 1; m_mode[d] = eff;
                for (int k = 0; k < CH; k++) m_val[d][k] = seed(w, eff, k);
            end else if (m_run[d] && e) begin
                for (int k = 0; k < CH; k++) begin
                    logic [63:0] o  = m_val[d][k];
                    logic [63:0] nv = o;
                    bit          wr = 1'b0;
                    bit          top = o[w-1];
                    case (m_mode[d])
                        1: begin nv = ((o << 1) | (o >> (w - 1))) & m; wr = top; end
                        2: begin nv = (o + 64'd1) & m; wr = (nv == 64'd0); end
                        3: begin
                            nv = ((o << 1) & m) ^ (top ? (m_poly[d] & m) : 64'd0);
                            wr = (nv == seed(w, 3, 0));
                        end
                        default: nv = o;
                    endcase
                    m_val[d][k] = nv;
                    if (k == 0) m_wrap[d] = wr;
                end
            end
        end
    endtask

    function automatic logic [127:0] packed_exp(input int d);
        logic [127:0] p = '0;
        for (int k = 0; k < CH; k++)
            p = p | (128'(m_val[d][k]) << (k * m_w[d]));
        return p;
    endfunction

    task automatic compare_all();
        check("a32",     a32,              packed_exp(0));
        check("valid32", 128'(valid32),    128'(m_valid[0]));
        check("wrap32",  128'(wrap32),     128'(m_wrap[0]));
        check("a8",      128'(a8),         packed_exp(1));
        check("valid8",  128'(valid8),     128'(m_valid[1]));
        check("wrap8",   128'(wrap8),      128'(m_wrap[1]));
    endtask

    // One clock: drive inputs, advance the model, sample on the falling edge.
    task automatic cyc(input bit rr, input logic [1:0] md, input bit ld, input bit e);
        r = rr; mode = md; mode_ld = ld; en = e;
        model_edge(rr, int'(md), ld, e);
        @(negedge c);
        compare_all();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 0; m_valid[d] = 0; m_wrap[d] = 0; m_mode[d] = 0;
            for (int k = 0; k < CH; k++) m_val[d][k] = 64'd0;
        end

        // Reset, then en while idle must leave everything at zero.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("reset_a32", a32, 128'd0);
        check("reset_valid32", 128'(valid32), 128'd0);
        for (int i = 0; i < 3; i++) cyc(0, 2, 0, 1);
        check("idle_en_a8", 128'(a8), 128'd0);
        check("idle_en_valid8", 128'(valid8), 128'd0);

        // STATIC stripe, en has no effect.
        cyc(0, 0, 1, 0);
        check("static_ch0", 128'(a32[31:0]), 128'h0000_0000_AAAA_AAAA);
        check("static_ch3", 128'(a32[127:96]), 128'h0000_0000_AAAA_AAAA);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 1);
        check("static_hold", 128'(a32[31:0]), 128'h0000_0000_AAAA_AAAA);

        // WALK: 32 steps, wrap only on the last.
        cyc(0, 1, 1, 0);
        check("walk_ch3_seed", 128'(a32[127:96]), 128'd8);
        for (int i = 0; i < 31; i++) cyc(0, 0, 0, 1);
        check("walk_ch0_msb", 128'(a32[31:0]), 128'h8000_0000);
        cyc(0, 0, 0, 1);
        check("walk_ch0_wrap", 128'(wrap32), 128'd1);
        check("walk_ch0_back", 128'(a32[31:0]), 128'd1);
        cyc(0, 0, 0, 0);
        check("walk_wrap_clear", 128'(wrap32), 128'd0);

        // COUNT on the 8-bit instance through its wrap.
        cyc(0, 2, 1, 0);
        check("count8_ch2_seed", 128'(a8[23:16]), 128'd2);
        for (int i = 0; i < 255; i++) cyc(0, 1, 0, 1);
        check("count8_ch0_255", 128'(a8[7:0]), 128'd255);
        cyc(0, 1, 0, 1);
        check("count8_ch0_zero", 128'(a8[7:0]), 128'd0);
        check("count8_wrap", 128'(wrap8), 128'd1);

        // mode_ld together with en mid-COUNT: reseed only.
        cyc(0, 2, 1, 0);
        for (int i = 0; i < 17; i++) cyc(0, 2, 0, 1);
        check("count_ch0_17", 128'(a32[31:0]), 128'd17);
        cyc(0, 1, 1, 1);
        check("ld_en_ch0", 128'(a32[31:0]), 128'd1);
        check("ld_en_wrap", 128'(wrap32), 128'd0);

        // PRBS load and first step (STATIC stripe when not built).
        cyc(0, 3, 1, 0);
        cyc(0, 0, 0, 1);
`ifdef FORLOOP_PATTERN_GEN_PRBS_EN
        check("prbs_step1", 128'(a32[31:0]), 128'hFFBF_FFF9);
`else
        check("prbs_off_static", 128'(a32[31:0]), 128'hAAAA_AAAA);
`endif

        // Reset mid-WALK with en high, then en ignored until reload.
        cyc(0, 1, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        check("rst_mid_a32", a32, 128'd0);
        check("rst_mid_valid", 128'(valid32), 128'd0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
        check("rst_then_en", a32, 128'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit         rr = ($urandom_range(0, 99) < 2);
            bit         ld = ($urandom_range(0, 99) < 8);
            bit         e  = ($urandom_range(0, 99) < 70);
            logic [1:0] md = 2'($urandom_range(0, 3));
            cyc(rr, md, ld, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
